// File: rtl/weight_drm_loader.sv
// Write-side producer for the weight DRM array: packs LANE_NUM narrow words into
// one DRM row and issues it as a single-cycle write at an incrementing row address.
module weight_drm_loader #(
  parameter int LANE_WIDTH    = 36,
  parameter int LANE_NUM      = 9,
  parameter int WR_ADDR_DEPTH = 10
) (
  input  logic                           wr_clk,
  input  logic                           rstn,
  input  logic                           load_start,
  input  logic [WR_ADDR_DEPTH-1:0]       load_base_addr,
  input  logic [WR_ADDR_DEPTH:0]         load_row_count,
  input  logic [LANE_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [LANE_WIDTH*LANE_NUM-1:0] WeightDRM_data_wr,
  output logic                           WeightDRM_valid_wr,
  output logic [WR_ADDR_DEPTH-1:0]       WeightDRM_addr_wr,
  output logic                           load_busy,
  output logic                           load_done
);

  localparam int ROW_W = LANE_WIDTH * LANE_NUM;
  localparam int LC_W  = $clog2(LANE_NUM);
  localparam int RC_W  = WR_ADDR_DEPTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state_r;
  state_t                          state_nxt_s;
  logic [LC_W-1:0]                 lane_cnt_r;
  logic [RC_W-1:0]                 row_cnt_r;
  logic [WR_ADDR_DEPTH-1:0]        base_r;
  logic [RC_W-1:0]                 count_r;
  logic [LANE_NUM-2:0][LANE_WIDTH-1:0] pack_r;
  logic [ROW_W-1:0]                data_wr_r;
  logic                            valid_wr_r;
  logic [WR_ADDR_DEPTH-1:0]        addr_wr_r;
  logic                            done_r;
  logic                            accept_s;
  logic                            row_end_s;
  logic                            last_row_s;
  logic                            start_ok_s;

  assign s_ready            = (state_r == LOAD);
  assign load_busy          = (state_r != IDLE);
  assign load_done          = done_r;
  assign WeightDRM_data_wr  = data_wr_r;
  assign WeightDRM_valid_wr = valid_wr_r;
  assign WeightDRM_addr_wr  = addr_wr_r;

  // Handshake decode and next-state selection
  always_comb begin
    state_nxt_s = state_r;
    start_ok_s  = (state_r == IDLE) && load_start;
    accept_s    = s_ready && s_valid;
    row_end_s   = accept_s && (lane_cnt_r == LC_W'(LANE_NUM - 1));
    last_row_s  = row_end_s && (row_cnt_r == (count_r - RC_W'(1)));
    case (state_r)
      IDLE: begin
        if (load_start) begin
          if (load_row_count != RC_W'(0)) begin
            state_nxt_s = LOAD;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (last_row_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command latch, lane packing and row write issue
  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      lane_cnt_r <= '0;
      row_cnt_r  <= '0;
      base_r     <= '0;
      count_r    <= '0;
      pack_r     <= '0;
      data_wr_r  <= '0;
      valid_wr_r <= 1'b0;
      addr_wr_r  <= '0;
      done_r     <= 1'b0;
    end else begin
      valid_wr_r <= 1'b0;
      // done trails the final strobe by one cycle, so it follows the DONE state
      done_r     <= (state_r == DONE);
      if (start_ok_s) begin
        base_r     <= load_base_addr;
        count_r    <= load_row_count;
        lane_cnt_r <= '0;
        row_cnt_r  <= '0;
      end
      if (row_end_s) begin
        data_wr_r  <= {s_data, pack_r};
        valid_wr_r <= 1'b1;
        addr_wr_r  <= base_r + row_cnt_r[WR_ADDR_DEPTH-1:0];
        lane_cnt_r <= '0;
        row_cnt_r  <= row_cnt_r + RC_W'(1);
      end else if (accept_s) begin
        for (int k = 0; k < LANE_NUM - 1; k++) begin
          if (lane_cnt_r == LC_W'(k)) begin
            pack_r[k] <= s_data;
          end
        end
        lane_cnt_r <= lane_cnt_r + LC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_weight_drm_loader.sv
// Bench for weight_drm_loader: table of load commands driven with random words and
// gaps, checked against a row/address model, plus reset and corner-case sequences.
module tb_weight_drm_loader;

  localparam int LW = 36;
  localparam int LN = 9;
  localparam int AW = 10;

  logic              wr_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              load_start = 1'b0;
  logic [AW-1:0]     load_base_addr = '0;
  logic [AW:0]       load_row_count = '0;
  logic [LW-1:0]     s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [LW*LN-1:0]  WeightDRM_data_wr;
  logic              WeightDRM_valid_wr;
  logic [AW-1:0]     WeightDRM_addr_wr;
  logic              load_busy;
  logic              load_done;

  weight_drm_loader dut (
    .wr_clk(wr_clk), .rstn(rstn), .load_start(load_start),
    .load_base_addr(load_base_addr), .load_row_count(load_row_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .WeightDRM_data_wr(WeightDRM_data_wr), .WeightDRM_valid_wr(WeightDRM_valid_wr),
    .WeightDRM_addr_wr(WeightDRM_addr_wr), .load_busy(load_busy), .load_done(load_done)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    int unsigned   addr;
    logic [LW*LN-1:0] data;
    int            cyc;
  } wr_t;

  typedef struct {
    int base;
    int count;
    int gap;
    int inject;
    bit fixed;
    int exp_first;
    int exp_last;
  } rec_t;

  rec_t tbl[8];
  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   strobes = 0;
  int   first_addr = -1;
  int   last_addr = -1;
  int   dones = 0;
  bit   done_armed = 1'b0;
  int   done_cyc_exp = 0;
  bit   rdy_seen = 1'b0;
  bit   rdy_ever = 1'b0;

  task automatic chk(input string nm, input logic [LW*LN-1:0] act, input logic [LW*LN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One clock cycle: observe outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    wr_t e;
    @(negedge wr_clk);
    rdy_seen = s_ready;
    if (s_ready) rdy_ever = 1'b1;
    if (rstn) begin
      if (WeightDRM_valid_wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 324'(WeightDRM_addr_wr), 324'(1024));
        end else begin
          e = exp_q.pop_front();
          chk("strobe_addr", 324'(WeightDRM_addr_wr), 324'(e.addr));
          chk("strobe_data", WeightDRM_data_wr, e.data);
          chk("strobe_cycle", 324'(cyc), 324'(e.cyc));
        end
        if (strobes == 0) first_addr = int'(WeightDRM_addr_wr);
        last_addr = int'(WeightDRM_addr_wr);
        strobes++;
      end
      if (load_done) begin
        if (!done_armed) chk("unexpected_done", 324'(1), 324'(0));
        else             chk("done_cycle", 324'(cyc), 324'(done_cyc_exp));
        done_armed = 1'b0;
        dones++;
      end
    end
    @(posedge wr_clk);
    #1;
    cyc++;
  endtask

  function automatic logic [LW-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[LW-1:0];
  endfunction

  // Present one word until accepted; returns 0 on timeout.
  task automatic feed_word(input logic [LW-1:0] w, input int gap, output bit ok);
    int budget;
    budget = 300;
    ok = 1'b0;
    s_data = w;
    while (budget > 0 && !ok) begin
      s_valid = (gap == 0) || (($urandom() % 100) >= gap);
      tick();
      budget--;
      if (s_valid && rdy_seen) ok = 1'b1;
      load_start = 1'b0;
    end
    s_valid = 1'b0;
    if (!ok) chk("word_accept_timeout", 324'(0), 324'(1));
  endtask

  task automatic wait_drain(input string nm);
    int budget;
    budget = 12;
    while (budget > 0 && (done_armed || exp_q.size() != 0)) begin
      tick();
      budget--;
    end
    chk(nm, 324'(done_armed || exp_q.size() != 0), 324'(0));
  endtask

  task automatic run_load(input rec_t r);
    logic [LW*LN-1:0] row;
    logic [LW-1:0]    w;
    bit               ok;
    int               widx;
    strobes = 0;
    first_addr = -1;
    last_addr = -1;
    rdy_ever = 1'b0;
    load_base_addr = AW'(r.base);
    load_row_count = (AW+1)'(r.count);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_base_addr = AW'($urandom());
    load_row_count = (AW+1)'($urandom());
    if (r.count == 0) begin
      done_armed = 1'b1;
      done_cyc_exp = cyc + 1;
      wait_drain("zero_count_done");
      chk("zero_count_never_ready", 324'(rdy_ever), 324'(0));
    end else begin
      widx = 0;
      for (int rr = 0; rr < r.count; rr++) begin
        row = '0;
        for (int k = 0; k < LN; k++) begin
          w = r.fixed ? LW'(k + 1) : rand_word();
          row[k*LW +: LW] = w;
          if (widx == r.inject) begin
            load_start = 1'b1;
            load_base_addr = AW'(500);
            load_row_count = (AW+1)'(1);
          end
          feed_word(w, r.gap, ok);
          if (!ok) return;
          widx++;
        end
        exp_q.push_back('{addr: (r.base + rr) % 1024, data: row, cyc: cyc});
      end
      done_armed = 1'b1;
      done_cyc_exp = cyc + 1;
      wait_drain("rows_and_done");
      chk("strobe_count", 324'(strobes), 324'(r.count));
      chk("first_addr", 324'(first_addr), 324'(r.exp_first));
      chk("last_addr", 324'(last_addr), 324'(r.exp_last));
    end
    chk("ready_low_after", 324'(s_ready), 324'(0));
    chk("busy_low_after", 324'(load_busy), 324'(0));
  endtask

  initial begin
    bit ok;
    int dones_before;
    tbl[0] = '{base: 0,    count: 1,    gap: 0,  inject: -1, fixed: 1'b1, exp_first: 0,    exp_last: 0};
    tbl[1] = '{base: 5,    count: 4,    gap: 0,  inject: -1, fixed: 1'b0, exp_first: 5,    exp_last: 8};
    tbl[2] = '{base: 33,   count: 2,    gap: 50, inject: -1, fixed: 1'b0, exp_first: 33,   exp_last: 34};
    tbl[3] = '{base: 1020, count: 6,    gap: 0,  inject: -1, fixed: 1'b0, exp_first: 1020, exp_last: 1};
    tbl[4] = '{base: 0,    count: 0,    gap: 0,  inject: -1, fixed: 1'b0, exp_first: -1,   exp_last: -1};
    tbl[5] = '{base: 100,  count: 3,    gap: 30, inject: 12, fixed: 1'b0, exp_first: 100,  exp_last: 102};
    tbl[6] = '{base: 700,  count: 5,    gap: 40, inject: -1, fixed: 1'b0, exp_first: 700,  exp_last: 704};
    tbl[7] = '{base: 0,    count: 1024, gap: 0,  inject: -1, fixed: 1'b0, exp_first: 0,    exp_last: 1023};

    #1;
    chk("reset_ready", 324'(s_ready), 324'(0));
    chk("reset_data", WeightDRM_data_wr, '0);
    chk("reset_outs", 324'({WeightDRM_valid_wr, WeightDRM_addr_wr, load_busy, load_done}), 324'(0));
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      run_load(tbl[i]);
      if (i == 0) begin
        chk("basic_row_lanes", WeightDRM_data_wr,
            {36'd9, 36'd8, 36'd7, 36'd6, 36'd5, 36'd4, 36'd3, 36'd2, 36'd1});
        chk("basic_row_addr_held", 324'(WeightDRM_addr_wr), 324'(0));
      end
      repeat (2) tick();
    end

    // Reset in the middle of the second row of a three-row load.
    exp_q.delete();
    load_base_addr = AW'(10);
    load_row_count = (AW+1)'(3);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    begin
      logic [LW*LN-1:0] row;
      row = '0;
      for (int k = 0; k < LN; k++) begin
        row[k*LW +: LW] = rand_word();
        feed_word(row[k*LW +: LW], 0, ok);
      end
      exp_q.push_back('{addr: 10, data: row, cyc: cyc});
    end
    for (int k = 0; k < 4; k++) feed_word(rand_word(), 0, ok);
    chk("row0_strobed_before_reset", 324'(exp_q.size()), 324'(0));
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_data", WeightDRM_data_wr, '0);
    chk("async_reset_outs",
        324'({s_ready, WeightDRM_valid_wr, WeightDRM_addr_wr, load_busy, load_done}), 324'(0));
    exp_q.delete();
    done_armed = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    dones_before = dones;
    s_valid = 1'b1;
    s_data = rand_word();
    repeat (20) tick();
    s_valid = 1'b0;
    chk("no_done_after_reset", 324'(dones), 324'(dones_before));
    chk("idle_after_reset", 324'(load_busy), 324'(0));
    run_load('{base: 77, count: 1, gap: 20, inject: -1, fixed: 1'b0, exp_first: 77, exp_last: 77});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_drm_loader.md
Name: weight_drm_loader

Overview:
- Write-side producer for the weight DRM array.
- Accepts a narrow stream of 36-bit weight words with valid/ready handshake and packs every 9 consecutive words into one 324-bit DRM row.
- Issues each packed row as a single-cycle write at an incrementing 10-bit row address, then signals completion so the read-side sequencer can start fetching 1296-bit rows.
- Sits between the off-chip weight fetch path and the DRM write port, on the write clock.

Parameters:
- LANE_WIDTH, 36, width of one input word and of one DRM write lane.
- LANE_NUM, 9, words packed per row (number of DRMs); row width = LANE_WIDTH*LANE_NUM = 324.
- WR_ADDR_DEPTH, 10, DRM write address width.

Ports:
- wr_clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse that begins a load; ignored while busy.
- load_base_addr  in  WR_ADDR_DEPTH  first row address, sampled on an accepted start.
- load_row_count  in  WR_ADDR_DEPTH+1  rows to write (0..1024), sampled on an accepted start.
- s_data  in  LANE_WIDTH  weight word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a word this cycle.
- WeightDRM_data_wr  out  LANE_WIDTH*LANE_NUM  packed row; lane k = word k of the row, at bits [k*36 +: 36].
- WeightDRM_valid_wr  out  1  one-cycle write strobe.
- WeightDRM_addr_wr  out  WR_ADDR_DEPTH  row address for the strobe.
- load_busy  out  1  load in progress.
- load_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: s_ready=0, WeightDRM_data_wr=0, WeightDRM_valid_wr=0, WeightDRM_addr_wr=0, load_busy=0, load_done=0. Internal lane counter, row counter and pack register are also cleared.
- FSM has three states: IDLE, LOAD, DONE.
- IDLE:
  - On load_start with load_row_count!=0: latch base and count, clear lane and row counters, go to LOAD.
  - On load_start with load_row_count==0: go to DONE with no writes.
- LOAD:
  - s_ready=1 combinationally from state only; it does not depend on s_valid.
  - A word is accepted on s_valid&&s_ready. It is stored in pack lane lane_cnt, and lane_cnt increments.
  - When accepting lane LANE_NUM-1, on the next edge: WeightDRM_data_wr <= {s_data, pack lanes LANE_NUM-2..0}; WeightDRM_valid_wr <= 1; WeightDRM_addr_wr <= base+row_cnt (modulo 2^WR_ADDR_DEPTH); lane_cnt <= 0; row_cnt increments.
  - Write latency is 1 cycle from accepting the last word of a row to the strobe.
  - Zero-bubble: the first word of the next row may be accepted in the same cycle the strobe is high.
  - If the completed row is row load_row_count-1, go to DONE; s_ready drops the cycle the strobe rises.
- DONE: load_done=1 for exactly one cycle, then IDLE. load_busy=1 in LOAD and DONE.
- WeightDRM_valid_wr is high for exactly one cycle per row. WeightDRM_data_wr and WeightDRM_addr_wr hold their last values when the strobe is low.
- s_valid gaps are tolerated anywhere. Partial rows are never written.
- Address wrap: base+row_cnt wraps past 2^WR_ADDR_DEPTH-1 to 0 with no error.
- load_start while busy (LOAD or DONE) is ignored; latched parameters are unchanged.
- Reset mid-load: state returns to IDLE immediately, the partial row is discarded, and no strobe or done follows.

Test Plan:
- Basic row: base=0, count=1, words 0x1..0x9 back-to-back -> single strobe 1 cycle after word 9, addr=0, data lane0=0x1..lane8=0x9; load_done exactly 1 cycle after the strobe; s_ready low thereafter.
- Streaming: base=5, count=4, 36 words, s_valid constant -> strobes at addr 5,6,7,8 spaced exactly 9 cycles apart; no dropped or stalled words; s_ready high throughout LOAD.
- Gapped input: count=2, s_valid toggled randomly (~50%) -> same two rows and addresses as the back-to-back case; strobe count=2.
- Wrap and full depth: base=1020, count=6 -> addresses 1020,1021,1022,1023,0,1. Separately count=1024, base=0 -> 1024 strobes, final addr=1023, one done pulse.
- Edge commands: count=0 -> done 1 cycle after start, no strobe, s_ready never high. load_start pulsed mid-load with different base -> ignored, original addresses continue.
- Reset mid-row: assert rstn=0 after word 4 of row 2 -> all outputs zero asynchronously; after release, no strobe and no done without a new start; a new start with count=1 writes a fresh row correctly.
